ahb_bus_arbiter: RTL and testbench
==================================

// Module: ahb_bus_arbiter
// PURPOSE
//  Round-robin AHB arbiter that shares the AHB2APB bridge slave port between NUM_MASTERS AHB masters.
//  It issues one-hot Hgrant and tracks the address- and data-phase owners (Hmaster, Hmaster_data) for the external Haddr/Hwdata muxes.
//  It honours locked sequences and parks the bus on DEFAULT_MASTER when idle.
//  Hready is the bridge's Hready_out.
// PARAMETERS
//  NUM_MASTERS     4   number of requesting masters (2..8)
//  MW              2   master-index width, $clog2(NUM_MASTERS)
//  DEFAULT_MASTER  0   park/reset owner
//  MAX_BEATS       16  tenure limit in beats (used only with ARB_BURST_LIMIT_EN)
// PORTS
//  Hclk          in   1            clock, rising edge
//  Hresetn       in   1            reset, asynchronous, active-low
//  Hbusreq       in   NUM_MASTERS  per-master bus request
//  Hlock         in   NUM_MASTERS  per-master locked-transfer request
//  Htrans        in   2            transfer type on the muxed address bus (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
//  Hready        in   1            transfer-complete strobe from the bridge
//  Hgrant        out  NUM_MASTERS  one-hot grant, registered
//  Hmaster       out  MW           address-phase owner
//  Hmaster_data  out  MW           data-phase owner
//  Hmastlock     out  1            current address phase is locked
// BEHAVIOUR
//  Reset (async, Hresetn=0):
//   - Hgrant=1<<DEFAULT_MASTER; Hmaster=Hmaster_data=DEFAULT_MASTER; Hmastlock=0.
//   - state=ARB_IDLE; rr_ptr=DEFAULT_MASTER. Outputs take these values immediately, also mid-transfer.
//  States:
//   - ARB_IDLE: no request; bus parked.
//   - ARB_OWN: owner granted.
//   - ARB_LOCK: owner holds lock.
//  Arbitration point (AP): Hready=1, Htrans is IDLE or NONSEQ, state!=ARB_LOCK.
//   - No AP while Htrans is BUSY/SEQ: bursts are never split (exception under CONFIGURATION).
//  At AP:
//   - Owner keeps the grant if Hbusreq[owner]=1.
//   - Otherwise the winner is the first set Hbusreq scanning rr_ptr+1 .. rr_ptr+NUM_MASTERS (mod NUM_MASTERS). rr_ptr<=winner.
//   - No request at all -> grant DEFAULT_MASTER, ARB_IDLE. Any winner -> ARB_OWN.
//  Hgrant changes on the edge after the AP: 1-cycle request->grant latency.
//  Pipeline, updated only on edges with Hready=1:
//   - Hmaster<=index(Hgrant); Hmaster_data<=Hmaster; Hmastlock<=Hlock[index(Hgrant)].
//  Hready=0: Hgrant, Hmaster, Hmaster_data, Hmastlock, state and rr_ptr all hold.
//  Lock:
//   - Hlock[owner]=1 at AP -> ARB_LOCK. Grant stays fixed regardless of other requests.
//   - Exit at the first Hready=1 cycle with Hlock[owner]=0 and Htrans IDLE/NONSEQ: normal AP that same cycle.
//  Boundary cases:
//   - Simultaneous requests: round-robin order only, no fixed priority.
//   - Request asserted and dropped before an AP: ignored.
//   - Owner drops Hbusreq mid-burst: grant held until the burst's AP.
//   - Hgrant is always exactly one-hot.
// CONFIGURATION
//  `ARB_BURST_LIMIT_EN defined:
//   - An MW+5-bit beat counter counts owner beats (Hready=1, Htrans NONSEQ/SEQ).
//   - It clears on every grant change.
//   - On reaching MAX_BEATS with another Hbusreq pending, a forced AP occurs on the next Hready=1 cycle, even during SEQ/BUSY.
//     The granted master must restart with NONSEQ (early burst termination).
//   - ARB_LOCK suppresses the forced AP.
//  Not defined: no counter; owner keeps the bus as long as Hbusreq[owner]=1 (starvation possible by design).
// STRUCTURE
//  Package ahb_arb_pkg:
//   - HTRANS_IDLE/BUSY/NONSEQ/SEQ localparams.
//   - Arbiter state enum ARB_IDLE/ARB_OWN/ARB_LOCK.
//   - Function onehot2idx.
//  Sub-module rr_priority_picker: combinational, (req, rr_ptr) -> one-hot winner + valid.
//  Top: state register, rr_ptr, grant/master pipeline, optional beat counter.
// TESTING
//  1. Reset, no requests -> Hgrant=4'b0001, Hmaster=0, Hmastlock=0. Assert Hresetn=0 mid-burst -> same values immediately.
//  2. Hbusreq=4'b0110, Htrans=IDLE, Hready=1, rr_ptr=0 -> Hgrant=4'b0010 next edge, Hmaster=1 one edge later.
//     Drop Hbusreq[1] -> next grant 4'b0100.
//  3. Owner 2 in SEQ burst, Hbusreq[3]=1 -> no grant change until Htrans=IDLE/NONSEQ with Hready=1.
//     Hready=0 for 3 cycles -> all outputs frozen.
//  4. Master 1 Hlock=1 with Hbusreq=4'b1111 -> Hgrant stays 4'b0010, Hmastlock=1.
//     Hlock drops at NONSEQ -> grant moves to 4'b0100.
//  5. ARB_BURST_LIMIT_EN, MAX_BEATS=4: owner 0 streams SEQ, Hbusreq[2]=1 -> grant 4'b0100 after the 4th beat.
//     Without the macro -> owner 0 keeps the grant.
//  6. Check every cycle: Hgrant one-hot; Hmaster_data equals the previous Hready-qualified Hmaster.

Source files
------------

// File: rtl/ahb_bus_arbiter_pkg.sv
// Shared types for the AHB round-robin arbiter.
// Transfer-type codes, arbiter states, one-hot to index helper.
package ahb_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OWN,
        ARB_LOCK
    } arb_state_e;

    // Supports up to 8 masters; callers zero-extend and truncate.
    function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) r = r | 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// Arbiter-side AHB signal bundle.
// slave: arbiter view; master: masters/bridge view.
interface ahb_arb_if #(
    parameter int NUM_MASTERS = 4,
    parameter int MW          = $clog2(NUM_MASTERS)
);
    logic [NUM_MASTERS-1:0] Hbusreq;
    logic [NUM_MASTERS-1:0] Hlock;
    logic [1:0]             Htrans;
    logic                   Hready;
    logic [NUM_MASTERS-1:0] Hgrant;
    logic [MW-1:0]          Hmaster;
    logic [MW-1:0]          Hmaster_data;
    logic                   Hmastlock;

    modport slave (
        input  Hbusreq, Hlock, Htrans, Hready,
        output Hgrant, Hmaster, Hmaster_data, Hmastlock
    );

    modport master (
        output Hbusreq, Hlock, Htrans, Hready,
        input  Hgrant, Hmaster, Hmaster_data, Hmastlock
    );
endinterface

// File: rtl/ahb_bus_arbiter_rr_priority_picker.sv
// Combinational round-robin picker.
// Scans ptr+1 .. ptr+N (mod N) and returns the first requester one-hot.
module rr_priority_picker #(
    parameter int NUM_MASTERS = 4,
    parameter int MW          = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [MW-1:0]          ptr_i,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output logic                   valid_o
);

    logic [MW-1:0] idx;
    logic          found;

    // First set request after the pointer wins; the pointer itself is last.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = MW'((int'(ptr_i) + i) % NUM_MASTERS);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter with lock support and bus parking.
// Optional beat-limited tenure under `ARB_BURST_LIMIT_EN.
module ahb_bus_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int MW             = $clog2(NUM_MASTERS),
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_BEATS      = 16
) (
    input logic      Hclk,
    input logic      Hresetn,
    ahb_arb_if.slave bus
);

    localparam logic [NUM_MASTERS-1:0] DEF_GNT =
        NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [MW-1:0]          master_q;
    logic [MW-1:0]          mdata_q;
    logic                   mastlock_q;

    logic [MW-1:0]          owner_idx;
    logic                   owner_req;
    logic                   owner_lock;
    logic                   trans_ap;
    logic                   normal_ap;
    logic                   forced;
    logic                   ap;
    logic [NUM_MASTERS-1:0] pick_req;
    logic [NUM_MASTERS-1:0] pick_gnt;
    logic                   pick_valid;

    assign owner_idx  = MW'(onehot2idx(8'(grant_q)));
    assign owner_req  = bus.Hbusreq[owner_idx];
    assign owner_lock = bus.Hlock[owner_idx];
    assign trans_ap   = (bus.Htrans == HTRANS_IDLE) ||
                        (bus.Htrans == HTRANS_NONSEQ);
    // A locked owner releases at the first boundary with Hlock low.
    assign normal_ap  = trans_ap &&
                        ((state_q != ARB_LOCK) || !owner_lock);
    assign ap         = bus.Hready && (normal_ap || forced);
    // A forced handover must never re-elect the current owner.
    assign pick_req   = forced ? (bus.Hbusreq & ~grant_q) : bus.Hbusreq;

`ifdef ARB_BURST_LIMIT_EN
    localparam int BW = MW + 5;
    localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_BEATS);

    logic [BW-1:0] beats_q;
    logic          limit_hit;

    assign limit_hit = (beats_q >= BEAT_MAX) &&
                       (|(bus.Hbusreq & ~grant_q));
    assign forced    = limit_hit && (state_q != ARB_LOCK);

    // Count address beats issued by the granted master; reset on handover.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            beats_q <= '0;
        end else if (grant_d != grant_q) begin
            beats_q <= '0;
        end else if (bus.Hready && bus.Htrans[1] &&
                     (master_q == owner_idx) && (beats_q < BEAT_MAX)) begin
            beats_q <= beats_q + 1'b1;
        end
    end
`else
    assign forced = 1'b0;
`endif

    rr_priority_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .MW          (MW)
    ) u_picker (
        .req_i   (pick_req),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (pick_gnt),
        .valid_o (pick_valid)
    );

    // Arbitration decision: keep, hand over round-robin, or park.
    always_comb begin
        grant_d  = grant_q;
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        if (ap) begin
            if (owner_req && !forced) begin
                state_d = owner_lock ? ARB_LOCK : ARB_OWN;
            end else if (pick_valid) begin
                grant_d  = pick_gnt;
                state_d  = ARB_OWN;
                rr_ptr_d = MW'(onehot2idx(8'(pick_gnt)));
            end else begin
                grant_d = DEF_GNT;
                state_d = ARB_IDLE;
            end
        end
    end

    // State, grant and address/data owner pipeline; all stall on Hready low.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q    <= ARB_IDLE;
            grant_q    <= DEF_GNT;
            rr_ptr_q   <= DEF_IDX;
            master_q   <= DEF_IDX;
            mdata_q    <= DEF_IDX;
            mastlock_q <= 1'b0;
        end else if (bus.Hready) begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            master_q   <= owner_idx;
            mdata_q    <= master_q;
            mastlock_q <= owner_lock;
        end
    end

    assign bus.Hgrant       = grant_q;
    assign bus.Hmaster      = master_q;
    assign bus.Hmaster_data = mdata_q;
    assign bus.Hmastlock    = mastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter (4 masters, MAX_BEATS=4).
// Covers reset, round-robin, burst hold, stall, lock, tenure limit.
module tb_ahb_bus_arbiter;

    localparam int N  = 4;
    localparam int MW = 2;

    logic Hclk;
    logic Hresetn;

    int n_chk  = 0;
    int n_pass = 0;

    ahb_arb_if #(.NUM_MASTERS(N), .MW(MW)) bus ();

    ahb_bus_arbiter #(
        .NUM_MASTERS    (N),
        .MW             (MW),
        .DEFAULT_MASTER (0),
        .MAX_BEATS      (4)
    ) dut (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .bus     (bus.slave)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge Hclk);
            #1;
        end
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] lck,
                         input logic [1:0] tr, input logic rdy);
        bus.Hbusreq = req;
        bus.Hlock   = lck;
        bus.Htrans  = tr;
        bus.Hready  = rdy;
    endtask

    task automatic outs(input string tag, input logic [3:0] g,
                        input logic [1:0] m, input logic [1:0] md,
                        input logic ml);
        chk({tag, ".gnt"}, 32'(bus.Hgrant), 32'(g));
        chk({tag, ".mst"}, 32'(bus.Hmaster), 32'(m));
        chk({tag, ".mdata"}, 32'(bus.Hmaster_data), 32'(md));
        chk({tag, ".lock"}, 32'(bus.Hmastlock), 32'(ml));
    endtask

    // Per-cycle invariants: one-hot grant, data owner trails address owner.
    always @(posedge Hclk) begin
        logic [1:0] pre_m;
        logic [1:0] pre_md;
        logic       pre_rdy;
        logic       pre_rst;
        pre_m   = bus.Hmaster;
        pre_md  = bus.Hmaster_data;
        pre_rdy = bus.Hready;
        pre_rst = Hresetn;
        #1;
        if (pre_rst && Hresetn) begin
            chk("onehot", 32'($onehot(bus.Hgrant)), 32'd1);
            chk("mdata_pipe", 32'(bus.Hmaster_data),
                32'(pre_rdy ? pre_m : pre_md));
        end
    end

    initial begin
        Hresetn = 1'b0;
        drive(4'b0000, 4'b0000, 2'b00, 1'b1);
        #12;
        outs("rst", 4'b0001, 2'd0, 2'd0, 1'b0);
        step();
        Hresetn = 1'b1;
        step();
        chk("park", 32'(bus.Hgrant), 32'h1);

        // Round-robin from rr_ptr=0: master 1 wins, then 2.
        drive(4'b0110, 4'b0000, 2'b00, 1'b1);
        step();
        chk("rr1.gnt", 32'(bus.Hgrant), 32'h2);
        chk("rr1.mst", 32'(bus.Hmaster), 32'd0);
        step();
        chk("rr1.keep", 32'(bus.Hgrant), 32'h2);
        chk("rr1.mst2", 32'(bus.Hmaster), 32'd1);
        drive(4'b0100, 4'b0000, 2'b00, 1'b1);
        step();
        chk("rr2.gnt", 32'(bus.Hgrant), 32'h4);

        // Owner 2 bursts; requester 3 waits, owner drops request mid-burst.
        drive(4'b1100, 4'b0000, 2'b10, 1'b1);
        step();
        chk("brst.nseq", 32'(bus.Hgrant), 32'h4);
        drive(4'b1000, 4'b0000, 2'b11, 1'b1);
        step();
        chk("brst.seq1", 32'(bus.Hgrant), 32'h4);
        step();
        chk("brst.seq2", 32'(bus.Hgrant), 32'h4);
        drive(4'b1000, 4'b0000, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            outs("stall", 4'b0100, 2'd2, 2'd2, 1'b0);
        end
        bus.Hready = 1'b1;
        step();
        chk("brst.end", 32'(bus.Hgrant), 32'h8);

        // Lock: master 1 locks, others requesting; release at NONSEQ.
        drive(4'b0010, 4'b0010, 2'b00, 1'b1);
        step();
        chk("lk.gnt", 32'(bus.Hgrant), 32'h2);
        chk("lk.ml0", 32'(bus.Hmastlock), 32'd0);
        drive(4'b1111, 4'b0010, 2'b10, 1'b1);
        step();
        chk("lk.keep", 32'(bus.Hgrant), 32'h2);
        chk("lk.ml1", 32'(bus.Hmastlock), 32'd1);
        drive(4'b1101, 4'b0010, 2'b00, 1'b1);
        step();
        chk("lk.hold1", 32'(bus.Hgrant), 32'h2);
        step();
        chk("lk.hold2", 32'(bus.Hgrant), 32'h2);
        chk("lk.ml2", 32'(bus.Hmastlock), 32'd1);
        drive(4'b1101, 4'b0000, 2'b10, 1'b1);
        step();
        chk("lk.rel", 32'(bus.Hgrant), 32'h4);
        chk("lk.ml3", 32'(bus.Hmastlock), 32'd0);

        // Asynchronous reset in the middle of a burst.
        drive(4'b1100, 4'b0000, 2'b11, 1'b1);
        step();
        Hresetn = 1'b0;
        #1;
        outs("rst_mid", 4'b0001, 2'd0, 2'd0, 1'b0);
        drive(4'b0000, 4'b0000, 2'b00, 1'b1);
        step();
        Hresetn = 1'b1;
        step();

        // Owner 0 streams; master 2 waits for the tenure limit.
        drive(4'b0001, 4'b0000, 2'b10, 1'b1);
        step();
        chk("lim.b1", 32'(bus.Hgrant), 32'h1);
        drive(4'b0101, 4'b0000, 2'b11, 1'b1);
        step(3);
        chk("lim.b4", 32'(bus.Hgrant), 32'h1);
        step();
`ifdef ARB_BURST_LIMIT_EN
        chk("lim.force", 32'(bus.Hgrant), 32'h4);
`else
        chk("lim.keep", 32'(bus.Hgrant), 32'h1);
        step(4);
        chk("lim.keep2", 32'(bus.Hgrant), 32'h1);
`endif
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
